// File: rtl/fpu_pkg.sv
// Shared constants and state encoding for the iterative single-precision divider.
package fpu_pkg;

   localparam int unsigned EXP_BIAS = 127;
   localparam int unsigned QBITS    = 26;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StDiv  = 2'd1,
      StNorm = 2'd2
   } state_e;

endpackage

// File: rtl/fdiv_mant_core.sv
// Restoring radix-2 mantissa divider: one quotient bit per step, MSB first.
module fdiv_mant_core
   import fpu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [23:0]      dividend,
   input  logic [23:0]      divisor,
   output logic [QBITS-1:0] q
);

   logic [24:0]      rem_q;
   logic [23:0]      div_q;
   logic [QBITS-1:0] q_q;
   logic             ge;
   logic [23:0]      diff;

   // Remainder stays below 2*divisor, so after a subtract it fits in 24 bits.
   always_comb begin
      ge   = rem_q >= {1'b0, div_q};
      diff = ge ? (rem_q[23:0] - div_q) : rem_q[23:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         div_q <= '0;
         q_q   <= '0;
      end else if (load) begin
         rem_q <= {1'b0, dividend};
         div_q <= divisor;
         q_q   <= '0;
      end else if (step) begin
         rem_q <= {diff, 1'b0};
         q_q   <= {q_q[QBITS-2:0], ge};
      end
   end

   assign q = q_q;

endmodule

// File: rtl/fdiv_iter.sv
// Iterative IEEE-754 single divider: fixed 27-cycle latency, truncating, denormals flushed.
module fdiv_iter
   import fpu_pkg::*;
#(
   parameter int unsigned QBITS = fpu_pkg::QBITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   output logic        ready,
   output logic        valid,
   output logic [31:0] y
);

   state_e            state_q, state_d;
   logic [4:0]        cnt_q;
   logic              sign_q, zx1_q, zx2_q;
   logic signed [9:0] e_q;
   logic              valid_q;
   logic [31:0]       y_q, y_d;
   logic [QBITS-1:0]  q;
   logic              accept, step;
   logic signed [9:0] exp_n;
   logic [22:0]       mant_n;
   logic              unused_qlsb;

   assign accept      = start && (state_q == StIdle);
   assign step        = (state_q == StDiv);
   assign unused_qlsb = q[0];

   fdiv_mant_core u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .step     (step),
      .dividend ({1'b1, x1[22:0]}),
      .divisor  ({1'b1, x2[22:0]}),
      .q        (q)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StDiv;
         StDiv:   if (cnt_q == 5'(QBITS - 1)) state_d = StNorm;
         StNorm:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Quotient lies in (0.5, 2): a clear MSB means one extra shift left.
   always_comb begin
      exp_n  = q[QBITS-1] ? e_q : e_q - 10'sd1;
      mant_n = q[QBITS-1] ? q[24:2] : q[23:1];
      if (zx2_q)                y_d = {sign_q, 8'hFF, 23'h0};
      else if (zx1_q)           y_d = {sign_q, 31'h0};
      else if (exp_n <= 10'sd0) y_d = {sign_q, 31'h0};
      else if (exp_n >= 10'sd255) y_d = {sign_q, 8'hFF, 23'h0};
      else                      y_d = {sign_q, exp_n[7:0], mant_n};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         zx1_q   <= 1'b0;
         zx2_q   <= 1'b0;
         e_q     <= '0;
         valid_q <= 1'b0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= (state_q == StNorm);
         if (accept) begin
            cnt_q  <= '0;
            sign_q <= x1[31] ^ x2[31];
            zx1_q  <= (x1[30:23] == 8'h00);
            zx2_q  <= (x2[30:23] == 8'h00);
            e_q    <= $signed({2'b00, x1[30:23]}) - $signed({2'b00, x2[30:23]})
                      + 10'(EXP_BIAS);
         end else if (step && cnt_q != 5'(QBITS - 1)) begin
            cnt_q <= cnt_q + 5'd1;
         end
         if (state_q == StNorm) y_q <= y_d;
      end
   end

   assign ready = (state_q == StIdle);
   assign valid = valid_q;
   assign y     = y_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Directed and randomized checks of fdiv_iter against an arithmetic reference model.
module tb_fdiv_iter;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [31:0] x1, x2, y;
   logic        ready, valid;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   fdiv_iter dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .x1    (x1),
      .x2    (x2),
      .ready (ready),
      .valid (valid),
      .y     (y)
   );

   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic   s;
      longint m1, m2, qv;
      int     e, mant;
      s = a[31] ^ b[31];
      if (b[30:23] == 0) return {s, 8'hFF, 23'h0};
      if (a[30:23] == 0) return {s, 31'h0};
      m1 = 64'h800000 + a[22:0];
      m2 = 64'h800000 + b[22:0];
      qv = (m1 * 64'd33554432) / m2;
      e  = int'(a[30:23]) - int'(b[30:23]) + 127;
      if (qv >= 64'd33554432) begin
         mant = int'((qv / 4) % 64'd8388608);
      end else begin
         e    = e - 1;
         mant = int'((qv / 2) % 64'd8388608);
      end
      if (e <= 0) return {s, 31'h0};
      if (e >= 255) return {s, 8'hFF, 23'h0};
      return {s, e[7:0], mant[22:0]};
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [7:0] e;
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 9) == 0) e = 8'h00;
      else if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(1, 254));
      else e = 8'($urandom_range(100, 154));
      return {r[31], e, r[22:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Drive a request sampled at the next rising edge (E0); leaves time at E0+1.
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      x1    = a;
      x2    = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      x1    = $urandom;
      x2    = $urandom;
      check("ready_low_after_accept", {31'h0, ready}, 32'h0);
   endtask

   // Walk edges E0+1..E0+27; optionally poke start while busy. Ends inside the valid cycle.
   task automatic finish(input logic [31:0] exp, input string tag, input int poke);
      int early;
      early = 0;
      for (int k = 1; k <= 26; k++) begin
         @(posedge clk);
         #1;
         if (valid || ready) early++;
         if (k == poke) begin
            start = 1'b1;
            x1    = rnd_fp();
            x2    = rnd_fp();
         end else if (k == poke + 1) begin
            start = 1'b0;
         end
      end
      check({tag, "_busy_window"}, early, 0);
      @(posedge clk);
      #1;
      check({tag, "_valid"}, {31'h0, valid}, 32'h1);
      check({tag, "_y"}, y, exp);
      check({tag, "_ready"}, {31'h0, ready}, 32'h1);
   endtask

   task automatic quiet(input int n, input string tag);
      int seen;
      seen = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (valid) seen++;
      end
      check({tag, "_no_valid"}, seen, 0);
   endtask

   logic [31:0] sp_a [4] = '{32'h3F800000, 32'h80000000, 32'h7F000000, 32'h00800000};
   logic [31:0] sp_b [4] = '{32'h00000000, 32'h3F800000, 32'h3F000000, 32'h40000000};
   logic [31:0] sp_y [4] = '{32'h7F800000, 32'h80000000, 32'h7F800000, 32'h00000000};

   initial begin
      logic [31:0] a, b;
      rst   = 1'b1;
      start = 1'b0;
      x1    = '0;
      x2    = '0;
      #12;
      check("reset_y", y, 32'h0);
      check("reset_valid", {31'h0, valid}, 32'h0);
      check("reset_ready", {31'h0, ready}, 32'h1);
      @(negedge clk);
      rst = 1'b0;

      issue(32'h40400000, 32'h3FC00000);
      finish(32'h40000000, "three_div_1p5", -1);
      quiet(1, "pulse_one_cycle");
      check("y_held", y, 32'h40000000);

      issue(32'h3F800000, 32'h40400000);
      finish(32'h3EAAAAAA, "one_third", -1);
      issue(32'hC0C00000, 32'h40000000);
      finish(32'hC0400000, "back_to_back", -1);
      quiet(2, "after_b2b");

      for (int i = 0; i < 4; i++) begin
         issue(sp_a[i], sp_b[i]);
         finish(sp_y[i], $sformatf("special%0d", i), -1);
         quiet(1, "after_special");
      end

      issue(32'h40400000, 32'h3FC00000);
      finish(32'h40000000, "busy_start_ignored", 5);
      quiet(30, "busy_start_single_pulse");

      issue(32'h3F800000, 32'h40400000);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      #2;
      check("midreset_valid", {31'h0, valid}, 32'h0);
      check("midreset_y", y, 32'h0);
      check("midreset_ready", {31'h0, ready}, 32'h1);
      @(negedge clk);
      rst = 1'b0;
      quiet(30, "aborted_op");
      check("aborted_y", y, 32'h0);
      issue(32'hC0C00000, 32'h40000000);
      finish(32'hC0400000, "after_reset", -1);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 0) quiet($urandom_range(1, 3), "rand_gap");
         a = rnd_fp();
         b = rnd_fp();
         issue(a, b);
         finish(ref_div(a, b), $sformatf("rand%0d_%08h_%08h", i, a, b), -1);
      end
      quiet(2, "tail");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
